// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and round-robin pick helper for the register-file write arbiter.
package regfile_pkg;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NPORTS = 2;
    localparam int REG_COUNT = 2 ** DEF_ADDR_W;
    localparam int PC_ADDR = REG_COUNT - 1;
    localparam int SEL_W = $clog2(DEF_NPORTS);
    localparam int MAX_PORTS = 16;

    // Lowest pending index at or above ptr wins; otherwise wrap to the lowest pending index.
    function automatic logic [MAX_PORTS-1:0] onehot_rr_pick(input logic [MAX_PORTS-1:0] pend, input int ptr);
        logic [MAX_PORTS-1:0] hi, lo;
        hi = '0;
        lo = '0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (pend[i] && i >= ptr) hi = MAX_PORTS'(1) << i;
            if (pend[i]) lo = MAX_PORTS'(1) << i;
        end
        return (hi != '0) ? hi : lo;
    endfunction
endpackage

// File: rtl/regfile_write_arbiter_decoder_n_cond.sv
// decoder_n_cond: conditional binary-to-one-hot decoder.
module decoder_n_cond #(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0]      in_i,
    input  logic                   cond_i,
    output logic [2**ADDR_W-1:0]   out_o
);
    assign out_o = cond_i ? (2**ADDR_W)'(1) << in_i : '0;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: buffers one write request per port and issues them round-robin
// as a registered one-hot register-file write enable, diverting PC writes to pc_we.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NPORTS = DEF_NPORTS,
    parameter bit PC_DIVERT = 1'b1,
    localparam int REG_N = 2 ** ADDR_W,
    localparam int SW = $clog2(NPORTS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS-1:0]        req_valid,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    output logic [NPORTS-1:0]        req_ready,
    input  logic                     flush,
    output logic [REG_N-1:0]         we,
    output logic                     pc_we,
    output logic [SW-1:0]            wr_sel,
    output logic                     wr_valid,
    output logic                     hazard
);
    logic [NPORTS-1:0] pend_q, pend_d, grant, accept;
    logic [ADDR_W-1:0] pend_addr_q [NPORTS];
    logic [ADDR_W-1:0] pend_addr_d [NPORTS];
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d, wr_sel_q, wr_sel_d, gsel;
    logic [ADDR_W-1:0] gaddr;
    logic [REG_N-1:0]  we_q, we_d;
    logic              pc_we_q, pc_we_d, wr_valid_q, hazard_q, hazard_d, issue, is_pc;

    always_comb begin
        grant = NPORTS'(onehot_rr_pick(MAX_PORTS'(pend_q), int'(rr_ptr_q)));
        gsel = '0;
        gaddr = '0;
        hazard_d = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant[i]) begin
                gsel = SW'(i);
                gaddr = pend_addr_q[i];
            end
            for (int j = i + 1; j < NPORTS; j++)
                if (pend_q[i] && pend_q[j] && pend_addr_q[i] == pend_addr_q[j]) hazard_d = !flush;
        end
        issue = (|grant) && !flush;
        is_pc = PC_DIVERT && gaddr == ADDR_W'(REG_N - 1);
        req_ready = ~pend_q | grant;
        accept = flush ? '0 : req_valid & req_ready;
        // A simultaneous accept refills a port whose entry is leaving this cycle.
        pend_d = flush ? '0 : accept | (pend_q & ~grant);
        for (int i = 0; i < NPORTS; i++)
            pend_addr_d[i] = accept[i] ? req_addr[i*ADDR_W +: ADDR_W] : pend_addr_q[i];
        rr_ptr_d = !issue ? rr_ptr_q : (gsel == SW'(NPORTS - 1)) ? '0 : gsel + 1'b1;
        wr_sel_d = issue ? gsel : wr_sel_q;
        pc_we_d = issue && is_pc;
    end

    decoder_n_cond #(.ADDR_W(ADDR_W)) u_dec (
        .in_i   (gaddr),
        .cond_i (issue && !is_pc),
        .out_o  (we_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            for (int i = 0; i < NPORTS; i++) pend_addr_q[i] <= '0;
            rr_ptr_q <= '0;
            we_q <= '0;
            pc_we_q <= 1'b0;
            wr_sel_q <= '0;
            wr_valid_q <= 1'b0;
            hazard_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            for (int i = 0; i < NPORTS; i++) pend_addr_q[i] <= pend_addr_d[i];
            rr_ptr_q <= rr_ptr_d;
            we_q <= we_d;
            pc_we_q <= pc_we_d;
            wr_sel_q <= wr_sel_d;
            wr_valid_q <= issue;
            hazard_q <= hazard_d;
        end
    end

    assign we = we_q;
    assign pc_we = pc_we_q;
    assign wr_sel = wr_sel_q;
    assign wr_valid = wr_valid_q;
    assign hazard = hazard_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios on 2-port instances plus a scoreboarded
// random run on a 3-port, 32-register instance.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]  a_valid = '0, a_ready;
    logic [7:0]  a_addr = '0;
    logic        a_flush = 1'b0, a_pc_we, a_sel, a_wv, a_hz;
    logic [15:0] a_we;

    logic [1:0]  b_valid = '0, b_ready;
    logic [7:0]  b_addr = '0;
    logic        b_flush = 1'b0, b_pc_we, b_sel, b_wv, b_hz;
    logic [15:0] b_we;

    logic [2:0]  c_valid = '0, c_ready;
    logic [14:0] c_addr = '0;
    logic        c_flush = 1'b0, c_pc_we, c_wv, c_hz;
    logic [1:0]  c_sel;
    logic [31:0] c_we;

    regfile_write_arbiter #(.ADDR_W(4), .NPORTS(2), .PC_DIVERT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_addr(a_addr), .req_ready(a_ready),
        .flush(a_flush), .we(a_we), .pc_we(a_pc_we), .wr_sel(a_sel), .wr_valid(a_wv), .hazard(a_hz));
    regfile_write_arbiter #(.ADDR_W(4), .NPORTS(2), .PC_DIVERT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_addr(b_addr), .req_ready(b_ready),
        .flush(b_flush), .we(b_we), .pc_we(b_pc_we), .wr_sel(b_sel), .wr_valid(b_wv), .hazard(b_hz));
    regfile_write_arbiter #(.ADDR_W(5), .NPORTS(3), .PC_DIVERT(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(c_valid), .req_addr(c_addr), .req_ready(c_ready),
        .flush(c_flush), .we(c_we), .pc_we(c_pc_we), .wr_sel(c_sel), .wr_valid(c_wv), .hazard(c_hz));

    logic [4:0] sbq [3][$];
    int waitc [3];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        a_valid = '0; a_flush = 1'b0; b_valid = '0; c_valid = '0; c_flush = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({a_we, a_pc_we, a_sel, a_wv, a_hz} !== 20'h0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", {a_we, a_pc_we, a_sel, a_wv, a_hz});
        end
        checks++;
        if ({a_ready, c_ready} !== 5'b11111) begin
            errors++; $display("FAIL reset_ready got %b want 11111", {a_ready, c_ready});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_midstream();
        a_valid = 2'b01; a_addr = 8'h03;
        tick();
        tick();
        a_valid = '0;
        checks++;
        if ({a_we, a_wv} !== {16'h0008, 1'b1}) begin
            errors++; $display("FAIL midrst_pre got we=%h v=%b want we=0008 v=1", a_we, a_wv);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_we, a_wv, a_pc_we} !== 18'h0) begin
            errors++; $display("FAIL midrst_async got we=%h v=%b want 0", a_we, a_wv);
        end
        checks++;
        if (a_ready !== 2'b11) begin
            errors++; $display("FAIL midrst_ready got %b want 11", a_ready);
        end
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if ({a_we, a_wv} !== 17'h0) begin
            errors++; $display("FAIL midrst_dropped got we=%h v=%b want 0", a_we, a_wv);
        end
    endtask

    task automatic test_single();
        do_reset();
        a_valid = 2'b01; a_addr = 8'h05;
        tick();
        a_valid = '0;
        checks++;
        if (a_wv !== 1'b0) begin
            errors++; $display("FAIL single_latency got v=%b want 0", a_wv);
        end
        tick();
        checks++;
        if ({a_we, a_sel, a_wv, a_pc_we} !== {16'h0020, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_issue got we=%h sel=%b v=%b want we=0020 sel=0 v=1", a_we, a_sel, a_wv);
        end
        tick();
        checks++;
        if ({a_we, a_wv} !== 17'h0) begin
            errors++; $display("FAIL single_once got we=%h v=%b want 0", a_we, a_wv);
        end
    endtask

    task automatic test_contention();
        do_reset();
        a_valid = 2'b11; a_addr = {4'h7, 4'h2};
        tick();
        checks++;
        if (a_ready !== 2'b01) begin
            errors++; $display("FAIL cont_ready got %b want 01", a_ready);
        end
        a_valid = 2'b01; a_addr = {4'h0, 4'hB};
        tick();
        a_valid = '0;
        checks++;
        if ({a_we, a_sel, a_wv} !== {16'h0004, 1'b0, 1'b1}) begin
            errors++; $display("FAIL cont_first got we=%h sel=%b want we=0004 sel=0", a_we, a_sel);
        end
        tick();
        checks++;
        if ({a_we, a_sel, a_wv} !== {16'h0080, 1'b1, 1'b1}) begin
            errors++; $display("FAIL cont_second got we=%h sel=%b want we=0080 sel=1", a_we, a_sel);
        end
        tick();
        checks++;
        if ({a_we, a_sel, a_wv} !== {16'h0800, 1'b0, 1'b1}) begin
            errors++; $display("FAIL cont_refill got we=%h sel=%b want we=0800 sel=0", a_we, a_sel);
        end
        tick();
        checks++;
        if ({a_we, a_sel, a_wv} !== {16'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL cont_idle got we=%h sel=%b v=%b want 0 sel held 0", a_we, a_sel, a_wv);
        end
    endtask

    task automatic test_pc_divert();
        do_reset();
        a_valid = 2'b10; a_addr = {4'hF, 4'h0};
        b_valid = 2'b10; b_addr = {4'hF, 4'h0};
        tick();
        a_valid = '0; b_valid = '0;
        tick();
        checks++;
        if ({a_we, a_pc_we, a_wv, a_sel} !== {16'h0, 1'b1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL pc_divert got we=%h pc=%b v=%b want we=0 pc=1 v=1", a_we, a_pc_we, a_wv);
        end
        checks++;
        if ({b_we, b_pc_we, b_wv, b_sel} !== {16'h8000, 1'b0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL pc_nodivert got we=%h pc=%b v=%b want we=8000 pc=0 v=1", b_we, b_pc_we, b_wv);
        end
    endtask

    task automatic test_hazard_flush();
        do_reset();
        a_valid = 2'b11; a_addr = {4'h9, 4'h9};
        tick();
        a_valid = '0;
        checks++;
        if (a_hz !== 1'b0) begin
            errors++; $display("FAIL hz_early got %b want 0", a_hz);
        end
        tick();
        checks++;
        if ({a_hz, a_we, a_sel} !== {1'b1, 16'h0200, 1'b0}) begin
            errors++; $display("FAIL hz_first got hz=%b we=%h sel=%b want hz=1 we=0200 sel=0", a_hz, a_we, a_sel);
        end
        tick();
        checks++;
        if ({a_hz, a_we, a_sel} !== {1'b0, 16'h0200, 1'b1}) begin
            errors++; $display("FAIL hz_second got hz=%b we=%h sel=%b want hz=0 we=0200 sel=1", a_hz, a_we, a_sel);
        end
        do_reset();
        a_valid = 2'b11; a_addr = {4'h9, 4'h9};
        tick();
        a_valid = 2'b01; a_addr = 8'h04; a_flush = 1'b1;
        tick();
        a_valid = '0; a_flush = 1'b0;
        checks++;
        if ({a_we, a_pc_we, a_wv, a_hz} !== 19'h0) begin
            errors++; $display("FAIL flush_idle got we=%h pc=%b v=%b hz=%b want 0", a_we, a_pc_we, a_wv, a_hz);
        end
        checks++;
        if (a_ready !== 2'b11) begin
            errors++; $display("FAIL flush_ready got %b want 11", a_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({a_we, a_pc_we, a_wv} !== 18'h0) begin
                errors++; $display("FAIL flush_nothing got we=%h pc=%b v=%b want 0", a_we, a_pc_we, a_wv);
            end
        end
    endtask

    function automatic logic [4:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        return (r == 0) ? 5'd31 : (r < 5) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        logic exp_hz;
        logic [4:0] got, exp_a;
        int gp;
        bit popped [3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sbq[i].delete();
            waitc[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit drive;
            drive = cyc < 2970;
            for (int i = 0; i < 3; i++) begin
                c_valid[i] = drive && ($urandom_range(0, 9) < 6);
                c_addr[i*5 +: 5] = rand_addr();
            end
            c_flush = drive && ($urandom_range(0, 59) == 0);
            #1;
            exp_hz = 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = i + 1; j < 3; j++)
                    if (sbq[i].size() > 0 && sbq[j].size() > 0 && sbq[i][0] == sbq[j][0]) exp_hz = !c_flush;
            for (int i = 0; i < 3; i++)
                if (sbq[i].size() == 0) begin
                    checks++;
                    if (c_ready[i] !== 1'b1) begin
                        errors++; $display("FAIL rnd_ready port %0d got %b want 1 (cycle %0d)", i, c_ready[i], cyc);
                    end
                end
            for (int i = 0; i < 3; i++)
                if (c_flush) begin
                    sbq[i].delete();
                    waitc[i] = 0;
                end else if (c_valid[i] && c_ready[i]) begin
                    sbq[i].push_back(c_addr[i*5 +: 5]);
                end
            tick();
            checks++;
            if (c_hz !== exp_hz) begin
                errors++; $display("FAIL rnd_hazard got %b want %b (cycle %0d)", c_hz, exp_hz, cyc);
            end
            checks++;
            if ($countones(c_we) > 1 || (c_we != 0 && c_pc_we) || c_wv !== (c_we != 0 || c_pc_we)) begin
                errors++; $display("FAIL rnd_onehot got we=%h pc=%b v=%b (cycle %0d)", c_we, c_pc_we, c_wv, cyc);
            end
            for (int i = 0; i < 3; i++) popped[i] = 1'b0;
            if (c_wv) begin
                gp = int'(c_sel);
                got = 5'd31;
                if (!c_pc_we)
                    for (int b = 0; b < 32; b++) if (c_we[b]) got = 5'(b);
                checks++;
                if (gp > 2 || sbq[gp].size() == 0) begin
                    errors++; $display("FAIL rnd_spurious got sel=%0d addr=%0d want no issue (cycle %0d)", gp, got, cyc);
                end else begin
                    exp_a = sbq[gp].pop_front();
                    popped[gp] = 1'b1;
                    if (got !== exp_a) begin
                        errors++; $display("FAIL rnd_addr port %0d got %0d want %0d (cycle %0d)", gp, got, exp_a, cyc);
                    end
                end
            end
            for (int i = 0; i < 3; i++)
                if (popped[i] || sbq[i].size() == 0) begin
                    waitc[i] = 0;
                end else begin
                    waitc[i]++;
                    checks++;
                    if (waitc[i] > 3) begin
                        errors++; $display("FAIL rnd_starve port %0d waited %0d want <=3 (cycle %0d)", i, waitc[i], cyc);
                    end
                end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sbq[i].size() != 0) begin
                errors++; $display("FAIL rnd_drain port %0d left %0d want 0", i, sbq[i].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_single();
        test_contention();
        test_pc_divert();
        test_hazard_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
